// File: rtl/sumador_n_bits.sv
// sumador_n_bits: registered WIDTH-bit add / subtract / accumulate / clear unit.
// Each accepted operation produces its result one cycle later on Q and RCO, and
// raises VALID for that one cycle. OVF is a sticky carry/borrow flag.
// RCI/RCO let several instances be chained into a wider multi-cycle add.
//
// Build option: define SUMADOR_SATURATE_EN to clamp results instead of wrapping.
//   add / accumulate with carry -> Q = 2^WIDTH-1
//   subtract with borrow        -> Q = 0
// RCO and OVF behave the same in both builds.
module sumador_n_bits #(
  parameter int WIDTH = 8  // operand/result width, 2..64
) (
  input  logic             CLK,
  input  logic             RESET_L,  // synchronous, active-low
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             RCI,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             VALID,
  output logic             OVF
);

  typedef enum logic [1:0] {
    MODO_ADD = 2'b00,
    MODO_SUB = 2'b01,
    MODO_ACC = 2'b10,
    MODO_CLR = 2'b11
  } modo_e;

  localparam logic [WIDTH-1:0] Q_MAX  = '1;
  localparam logic [WIDTH-1:0] Q_ZERO = '0;

  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  modo_e            modo;
  logic [WIDTH-1:0] add_lhs;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             carry;
  logic             borrow;

  // Arithmetic datapath, evaluated at WIDTH+1 bits so the top bit is carry/borrow.
  always_comb begin
    modo    = modo_e'(MODO);
    // Accumulate reuses the adder with the current result in place of B.
    add_lhs = (modo == MODO_ACC) ? q_q : B;
    sum_ext  = {1'b0, A} + {1'b0, add_lhs} + {{WIDTH{1'b0}}, RCI};
    // A borrow leaves the (WIDTH+1)-bit difference negative, so its top bit is 1.
    diff_ext = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, RCI};
    carry    = sum_ext[WIDTH];
    borrow   = diff_ext[WIDTH];
  end

  // Next-state selection for result, carry, valid and sticky overflow.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    q_d     = q_q;
    rco_d   = rco_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (ENB) begin
      valid_d = 1'b1;
      unique case (modo)
        MODO_ADD, MODO_ACC: begin
          rco_d = carry;
          ovf_d = ovf_q | carry;
`ifdef SUMADOR_SATURATE_EN
          q_d   = carry ? Q_MAX : sum_ext[WIDTH-1:0];
`else
          q_d   = sum_ext[WIDTH-1:0];
`endif
        end
        MODO_SUB: begin
          rco_d = borrow;
          ovf_d = ovf_q | borrow;
`ifdef SUMADOR_SATURATE_EN
          q_d   = borrow ? Q_ZERO : diff_ext[WIDTH-1:0];
`else
          q_d   = diff_ext[WIDTH-1:0];
`endif
        end
        MODO_CLR: begin
          q_d   = Q_ZERO;
          rco_d = 1'b0;
          ovf_d = 1'b0;
        end
        default: begin
          q_d   = q_q;
          rco_d = rco_q;
          ovf_d = ovf_q;
        end
      endcase
    end
  end

  // State registers; reset is sampled on the clock edge and overrides any operation.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RESET_L) begin
      q_q     <= '0;
      rco_q   <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      rco_q   <= rco_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q     = q_q;
  assign RCO   = rco_q;
  assign VALID = valid_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_sumador_n_bits.sv
// Testbench for sumador_n_bits: directed vector table, a WIDTH=16 cascade
// sequence, and randomized traffic checked against an arithmetic model.
module tb_sumador_n_bits;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         enb;
  logic [1:0]   modo;
  logic [W-1:0] a, b;
  logic         rci;
  logic [W-1:0] q;
  logic         rco, valid, ovf;

  // WIDTH=16 cascade pair
  logic         lo_enb, hi_enb, hi_rci;
  logic [15:0]  lo_a, lo_b, hi_a, hi_b, lo_q, hi_q;
  logic         lo_rco, hi_rco, lo_valid, hi_valid, lo_ovf, hi_ovf;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef SUMADOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  sumador_n_bits #(.WIDTH(W)) dut (
    .CLK(clk), .RESET_L(rst_n), .ENB(enb), .MODO(modo), .A(a), .B(b), .RCI(rci),
    .Q(q), .RCO(rco), .VALID(valid), .OVF(ovf)
  );

  sumador_n_bits #(.WIDTH(16)) dut_lo (
    .CLK(clk), .RESET_L(rst_n), .ENB(lo_enb), .MODO(2'b00), .A(lo_a), .B(lo_b),
    .RCI(1'b0), .Q(lo_q), .RCO(lo_rco), .VALID(lo_valid), .OVF(lo_ovf)
  );

  sumador_n_bits #(.WIDTH(16)) dut_hi (
    .CLK(clk), .RESET_L(rst_n), .ENB(hi_enb), .MODO(2'b00), .A(hi_a), .B(hi_b),
    .RCI(hi_rci), .Q(hi_q), .RCO(hi_rco), .VALID(hi_valid), .OVF(hi_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         enb;
    logic [1:0]   modo;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rci;
    logic [W-1:0] exp_q;      // wrapping build
    logic [W-1:0] exp_q_sat;  // saturating build
    logic         exp_rco;
    logic         exp_valid;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mkv(logic r, logic e, logic [1:0] m, logic [W-1:0] va,
                               logic [W-1:0] vb, logic c, logic [W-1:0] eq,
                               logic [W-1:0] eqs, logic er, logic ev, logic eo);
    vec_t v;
    v.rst_n = r; v.enb = e; v.modo = m; v.a = va; v.b = vb; v.rci = c;
    v.exp_q = eq; v.exp_q_sat = eqs; v.exp_rco = er; v.exp_valid = ev; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drive on the falling edge, let the rising edge happen, sample 1 time unit later.
  task automatic apply(input logic r, input logic e, input logic [1:0] m,
                       input logic [W-1:0] va, input logic [W-1:0] vb, input logic c);
    @(negedge clk);
    rst_n = r; enb = e; modo = m; a = va; b = vb; rci = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model state: plain integers following the operation definitions.
  int m_q, m_rco, m_valid, m_ovf;

  task automatic model_step(input logic r, input logic e, input logic [1:0] m,
                            input int va, input int vb, input int c);
    int maxv, t;
    maxv = (1 << W) - 1;
    if (!r) begin
      m_q = 0; m_rco = 0; m_valid = 0; m_ovf = 0;
    end else if (!e) begin
      m_valid = 0;
    end else begin
      m_valid = 1;
      case (m)
        2'd0, 2'd2: begin
          t     = va + ((m == 2'd0) ? vb : m_q) + c;
          m_rco = (t > maxv) ? 1 : 0;
          m_q   = (SAT && m_rco == 1) ? maxv : t % (maxv + 1);
          if (m_rco == 1) m_ovf = 1;
        end
        2'd1: begin
          m_rco = (va < vb + c) ? 1 : 0;
          m_q   = (SAT && m_rco == 1) ? 0 : (va - vb - c + 2 * (maxv + 1)) % (maxv + 1);
          if (m_rco == 1) m_ovf = 1;
        end
        default: begin
          m_q = 0; m_rco = 0; m_ovf = 0;
        end
      endcase
    end
  endtask

  initial begin
    rst_n = 1'b0; enb = 1'b0; modo = 2'b00; a = '0; b = '0; rci = 1'b0;
    lo_enb = 1'b0; hi_enb = 1'b0; hi_rci = 1'b0;
    lo_a = '0; lo_b = '0; hi_a = '0; hi_b = '0;

    // Reset held with an operation pending; it must be discarded.
    vecs[0]  = mkv(0, 1, 2'b00, 8'h80, 8'h80, 0, 8'h00, 8'h00, 0, 0, 0);
    vecs[1]  = mkv(1, 1, 2'b00, 8'h01, 8'h01, 0, 8'h02, 8'h02, 0, 1, 0);
    vecs[2]  = mkv(1, 1, 2'b00, 8'hF0, 8'h20, 1, 8'h11, 8'hFF, 1, 1, 1);
    vecs[3]  = mkv(1, 1, 2'b01, 8'h05, 8'h07, 0, 8'hFE, 8'h00, 1, 1, 1);
    vecs[4]  = mkv(1, 1, 2'b01, 8'h07, 8'h05, 0, 8'h02, 8'h02, 0, 1, 1);
    vecs[5]  = mkv(1, 1, 2'b11, 8'hAA, 8'h55, 1, 8'h00, 8'h00, 0, 1, 0);
    vecs[6]  = mkv(1, 1, 2'b10, 8'h40, 8'hFF, 0, 8'h40, 8'h40, 0, 1, 0);
    vecs[7]  = mkv(1, 1, 2'b10, 8'h40, 8'h13, 0, 8'h80, 8'h80, 0, 1, 0);
    vecs[8]  = mkv(1, 1, 2'b10, 8'h40, 8'h77, 0, 8'hC0, 8'hC0, 0, 1, 0);
    vecs[9]  = mkv(1, 1, 2'b10, 8'h40, 8'h00, 0, 8'h00, 8'hFF, 1, 1, 1);
    vecs[10] = mkv(1, 1, 2'b11, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0);
    vecs[11] = mkv(1, 1, 2'b00, 8'h33, 8'h00, 0, 8'h33, 8'h33, 0, 1, 0);
    // Hold: ENB low, including a clear that must be ignored.
    vecs[12] = mkv(1, 0, 2'b11, 8'h12, 8'h34, 1, 8'h33, 8'h33, 0, 0, 0);
    vecs[13] = mkv(1, 0, 2'b00, 8'hFF, 8'hFF, 1, 8'h33, 8'h33, 0, 0, 0);
    vecs[14] = mkv(1, 0, 2'b01, 8'h00, 8'h9C, 0, 8'h33, 8'h33, 0, 0, 0);
    // Accumulate wrap: Q=FF then +1.
    vecs[15] = mkv(1, 1, 2'b00, 8'hFF, 8'h00, 0, 8'hFF, 8'hFF, 0, 1, 0);
    vecs[16] = mkv(1, 1, 2'b10, 8'h01, 8'hEE, 0, 8'h00, 8'hFF, 1, 1, 1);
    // Add with ripple-in only, no carry; OVF stays set.
    vecs[17] = mkv(1, 1, 2'b00, 8'h00, 8'h00, 1, 8'h01, 8'h01, 0, 1, 1);
    // Reset with ENB low clears the sticky flag.
    vecs[18] = mkv(0, 0, 2'b10, 8'h11, 8'h22, 1, 8'h00, 8'h00, 0, 0, 0);
    // First edge after reset with ENB high is accepted.
    vecs[19] = mkv(1, 1, 2'b01, 8'h10, 8'h01, 1, 8'h0E, 8'h0E, 0, 1, 0);

    apply(0, 0, 2'b00, '0, '0, 0);
    check("reset_q", 64'(q), 64'h0);
    check("reset_rco", 64'(rco), 64'h0);
    check("reset_valid", 64'(valid), 64'h0);
    check("reset_ovf", 64'(ovf), 64'h0);

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].rst_n, vecs[i].enb, vecs[i].modo, vecs[i].a, vecs[i].b, vecs[i].rci);
      check($sformatf("vec%0d_q", i), 64'(q), SAT ? 64'(vecs[i].exp_q_sat) : 64'(vecs[i].exp_q));
      check($sformatf("vec%0d_rco", i), 64'(rco), 64'(vecs[i].exp_rco));
      check($sformatf("vec%0d_valid", i), 64'(valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].exp_ovf));
    end

    // WIDTH=16 cascade: low word carry feeds high word on the next cycle.
    @(negedge clk);
    rst_n = 1'b1; enb = 1'b0;
    lo_enb = 1'b1; lo_a = 16'hFFFF; lo_b = 16'h0001;
    hi_enb = 1'b0;
    @(posedge clk); #1;
    check("casc_lo_q", 64'(lo_q), 64'h0);
    check("casc_lo_rco", 64'(lo_rco), 64'h1);
    check("casc_hi_idle_valid", 64'(hi_valid), 64'h0);
    @(negedge clk);
    lo_enb = 1'b0;
    hi_enb = 1'b1; hi_a = 16'h0000; hi_b = 16'h0000; hi_rci = lo_rco;
    @(posedge clk); #1;
    check("casc_hi_q", 64'(hi_q), 64'h1);
    check("casc_hi_rco", 64'(hi_rco), 64'h0);
    check("casc_lo_hold_rco", 64'(lo_rco), 64'h1);
    @(negedge clk);
    hi_enb = 1'b0; hi_rci = 1'b0;

    // Randomized traffic against the model, starting from a forced reset.
    m_q = 0; m_rco = 0; m_valid = 0; m_ovf = 0;
    for (int i = 0; i < 400; i++) begin
      logic         r_rst, r_enb, r_rci;
      logic [1:0]   r_modo;
      logic [W-1:0] r_a, r_b;
      r_rst  = (i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
      r_enb  = ($urandom_range(0, 4) != 0);
      // Clears kept rare so OVF and accumulate chains get exercised.
      r_modo = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_a    = W'($urandom_range(0, (1 << W) - 1));
      r_b    = W'($urandom_range(0, (1 << W) - 1));
      r_rci  = 1'($urandom_range(0, 1));
      model_step(r_rst, r_enb, r_modo, int'(r_a), int'(r_b), int'(r_rci));
      apply(r_rst, r_enb, r_modo, r_a, r_b, r_rci);
      check($sformatf("rnd%0d_q", i), 64'(q), 64'(m_q));
      check($sformatf("rnd%0d_rco", i), 64'(rco), 64'(m_rco));
      check($sformatf("rnd%0d_valid", i), 64'(valid), 64'(m_valid));
      check($sformatf("rnd%0d_ovf", i), 64'(ovf), 64'(m_ovf));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sumador_n_bits.md
SUMADOR_N_BITS -- requirements
Module: sumador_n_bits

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal values 2 to 64.
REQ-002 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 RESET_L  input  1  reset, synchronous and active-low, sampled on the rising edge of CLK.
REQ-004 ENB  input  1  operation enable; when low, all state SHALL hold.
REQ-005 MODO  input  2  operation select.
REQ-006 A  input  WIDTH  operand A, unsigned.
REQ-007 B  input  WIDTH  operand B, unsigned.
REQ-008 RCI  input  1  ripple carry/borrow in, for cascading instances.
REQ-009 Q  output  WIDTH  registered result.
REQ-010 RCO  output  1  registered ripple carry/borrow out for the current result.
REQ-011 VALID  output  1  registered; high for exactly the cycle after each accepted operation.
REQ-012 OVF  output  1  registered sticky overflow flag.

Function
REQ-013 An operation SHALL be accepted on a rising edge where RESET_L=1 and ENB=1; the result SHALL appear on Q and RCO one cycle later (latency 1).
REQ-014 MODO=00 (add) SHALL produce {RCO,Q} <= A + B + RCI, computed at WIDTH+1 bits.
REQ-015 MODO=01 (subtract) SHALL produce Q <= (A - B - RCI) mod 2^WIDTH; RCO SHALL be 1 exactly when A < B + RCI (borrow).
REQ-016 MODO=10 (accumulate) SHALL produce {RCO,Q} <= Q + A + RCI; B SHALL be ignored.
REQ-017 MODO=11 (clear) SHALL set Q <= 0, RCO <= 0 and OVF <= 0; A, B and RCI SHALL be ignored.
REQ-018 OVF SHALL set on any accepted add, subtract or accumulate with RCO result 1, and SHALL stay set until MODO=11 is accepted or reset is applied.
REQ-019 VALID SHALL be 1 in the cycle after every accepted operation, MODO=11 included, and 0 otherwise; back-to-back accepts SHALL hold VALID high continuously.
REQ-020 With ENB=0, Q, RCO and OVF SHALL hold, and VALID SHALL drop to 0 on the next edge.
REQ-021 Accumulate wrap-around: Q=2^WIDTH-1, A=1, RCI=0 SHALL give Q=0 and RCO=1 (wrap build).
REQ-022 Cascading: the RCO of instance k, fed to the RCI of instance k+1 in the following cycle, SHALL form a multi-cycle wider add; the block SHALL NOT combinationally pass RCI to RCO.

Reset
REQ-023 RESET_L=0 at a rising edge SHALL force Q=0, RCO=0, VALID=0 and OVF=0, regardless of ENB or MODO.
REQ-024 Reset SHALL take priority over an operation accepted in the same cycle; that operation SHALL be discarded and produce no VALID.
REQ-025 After RESET_L returns high, the first operation SHALL be accepted on the first edge with ENB=1.

Configuration
REQ-026 Macro SUMADOR_SATURATE_EN, when defined, SHALL make add and accumulate clamp Q to 2^WIDTH-1 on carry, and make subtract clamp Q to 0 on borrow.
REQ-027 Under SUMADOR_SATURATE_EN, RCO and OVF SHALL behave exactly as in REQ-014 to REQ-018.
REQ-028 Without SUMADOR_SATURATE_EN, results SHALL wrap modulo 2^WIDTH as in REQ-014 to REQ-016.

Verification (WIDTH=8 unless noted)
REQ-029 Add: MODO=00, A=0xF0, B=0x20, RCI=1, ENB=1 -> next cycle Q=0x11, RCO=1, VALID=1, OVF=1; with SUMADOR_SATURATE_EN, Q=0xFF.
REQ-030 Subtract: MODO=01, A=0x05, B=0x07, RCI=0 -> Q=0xFE, RCO=1; with SUMADOR_SATURATE_EN, Q=0x00. Then A=0x07, B=0x05 -> Q=0x02, RCO=0, OVF stays 1.
REQ-031 Accumulate: clear, then MODO=10, A=0x40 for 4 accepted cycles -> Q sequence 0x40, 0x80, 0xC0, 0x00 with RCO=1 on the last; VALID high for all 4 cycles.
REQ-032 Hold: Q=0x33, then ENB=0 for 3 cycles with arbitrary A, B and MODO -> Q=0x33 unchanged, VALID=0 from the first ENB=0 edge.
REQ-033 Reset mid-operation: RESET_L=0 in the same cycle as ENB=1, MODO=00, A=B=0x80 -> Q=0, RCO=0, OVF=0, VALID=0; next accepted add of 0x01+0x01 -> Q=0x02.
REQ-034 WIDTH=16 cascade: low instance A=0xFFFF, B=0x0001 -> RCO=1; feeding it to the high instance RCI with A=B=0 -> Q=0x0001.
